// File: rtl/neuraedge_ws_sequencer.sv
// Purpose : weight-stationary dataflow sequencer for one PE array. It loads weight rows,
//           streams activation vectors, drains the systolic pipe and hands out results.
// Latency : first result on advance rows+PE_COLS-2 (0-based) after COMPUTE entry.
//           done pulses in the cycle after the advance that carries res_last.
// Backpr. : array_en is the only advance enable. It drops on a missing activation while
//           injecting, or on res_ready=0 while a result is due.
// Ports   : cmd_*  command handshake (accepted in IDLE only)
//           wgt_*  weight-row load handshake
//           act_*  activation stream
//           res_*  result stream
//           busy/done/err status; perf_stall_cnt stall counter
// Config  : define NEURAEDGE_SEQ_PERF_EN to build the stall counter; otherwise perf_stall_cnt reads 0.
module neuraedge_ws_sequencer #(
  parameter int PE_ROWS = 32,
  parameter int PE_COLS = 64,
  parameter int K_MAX_W = 16,
  localparam int ROW_W  = $clog2(PE_ROWS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [ROW_W:0]     cmd_num_rows,
  input  logic [K_MAX_W-1:0] cmd_num_vec,
  input  logic               cmd_reuse_w,
  input  logic               wgt_valid,
  output logic               wgt_ready,
  output logic [ROW_W-1:0]   wgt_row_sel,
  output logic               wgt_load_en,
  input  logic               act_valid,
  output logic               act_ready,
  output logic               act_bubble,
  output logic               array_en,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               res_last,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [31:0]        perf_stall_cnt
);

  // The advance counter must reach num_vec + L - 2, which needs one bit beyond K_MAX_W.
  localparam int SC_W = K_MAX_W + 1;
  localparam logic [ROW_W:0] ROWS_MAX = (ROW_W+1)'(PE_ROWS);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_W  = 3'd1,
    COMPUTE = 3'd2,
    DRAIN   = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [ROW_W:0]     row_q, row_d;
  logic [ROW_W:0]     rows_q, rows_d;
  logic [K_MAX_W-1:0] num_vec_q, num_vec_d;
  logic [SC_W-1:0]    sc_q, sc_d;
  logic               err_q, err_d;
  logic               cmd_acc;

  // Derived advance indices.
  // lat_m1  = L - 1 : first advance that produces a result
  // last_sc = num_vec + L - 2 : final advance
  // vec_m1  = num_vec - 1 : advance that consumes the last activation
  logic [SC_W-1:0] lat_m1, last_sc, vec_m1;
  logic            out_phase;
  logic            cmd_illegal;

  assign lat_m1      = SC_W'(rows_q) + SC_W'(PE_COLS - 2);
  assign last_sc     = SC_W'(num_vec_q) + lat_m1 - SC_W'(1);
  assign vec_m1      = SC_W'(num_vec_q) - SC_W'(1);
  assign out_phase   = (sc_q >= lat_m1);
  assign cmd_illegal = (cmd_num_rows == '0) || (cmd_num_rows > ROWS_MAX);
  assign err         = err_q;

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    rows_d      = rows_q;
    num_vec_d   = num_vec_q;
    sc_d        = sc_q;
    err_d       = 1'b0;
    cmd_acc     = 1'b0;
    cmd_ready   = 1'b0;
    wgt_ready   = 1'b0;
    wgt_row_sel = '0;
    wgt_load_en = 1'b0;
    act_ready   = 1'b0;
    act_bubble  = 1'b0;
    array_en    = 1'b0;
    res_valid   = 1'b0;
    res_last    = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;

    case (state_q)
      IDLE: begin
        busy      = 1'b0;
        // Hold off a new command while the error pulse of the previous one is out.
        cmd_ready = !err_q;
        if (cmd_valid && cmd_ready) begin
          cmd_acc   = 1'b1;
          rows_d    = cmd_num_rows;
          num_vec_d = cmd_num_vec;
          row_d     = '0;
          sc_d      = '0;
          if (cmd_illegal) begin
            err_d = 1'b1;
          end else if (cmd_reuse_w) begin
            state_d = (cmd_num_vec == '0) ? DONE : COMPUTE;
          end else begin
            state_d = LOAD_W;
          end
        end
      end

      LOAD_W: begin
        wgt_ready   = 1'b1;
        wgt_row_sel = row_q[ROW_W-1:0];
        wgt_load_en = wgt_valid;
        if (wgt_valid) begin
          if (row_q == rows_q - (ROW_W+1)'(1)) begin
            sc_d    = '0;
            state_d = (num_vec_q == '0) ? DONE : COMPUTE;
          end else begin
            row_d = row_q + (ROW_W+1)'(1);
          end
        end
      end

      COMPUTE: begin
        // Every advance here injects one real activation. Once results emerge,
        // an advance also needs the downstream to take the result.
        act_ready = !out_phase || res_ready;
        array_en  = act_valid && act_ready;
        res_valid = out_phase && act_valid;
        res_last  = res_valid && (sc_q == last_sc);
        if (array_en) begin
          sc_d = sc_q + SC_W'(1);
          if (sc_q == vec_m1) begin
            state_d = DRAIN;
          end
        end
      end

      DRAIN: begin
        act_bubble = 1'b1;
        array_en   = !out_phase || res_ready;
        res_valid  = out_phase;
        res_last   = res_valid && (sc_q == last_sc);
        if (array_en) begin
          sc_d = sc_q + SC_W'(1);
          if (sc_q == last_sc) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      row_q     <= '0;
      rows_q    <= '0;
      num_vec_q <= '0;
      sc_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      rows_q    <= rows_d;
      num_vec_q <= num_vec_d;
      sc_q      <= sc_d;
      err_q     <= err_d;
    end
  end

`ifdef NEURAEDGE_SEQ_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (cmd_acc) begin
      perf_d = '0;
    end else if (((state_q == COMPUTE) || (state_q == DRAIN)) && !array_en && (perf_q != '1)) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_stall_cnt = perf_q;
`else
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_neuraedge_ws_sequencer.sv
// Bench for neuraedge_ws_sequencer. A table of directed commands is run first, then the
// mid-compute reset sequence, then random commands under random valid/ready. Each command
// is checked cycle by cycle against a model that reasons in terms of "rows loaded" and
// "advances made".
module tb_neuraedge_ws_sequencer;
  localparam int PE_ROWS = 32;
  localparam int PE_COLS = 64;
  localparam int K_MAX_W = 16;
  localparam int ROW_W   = $clog2(PE_ROWS);

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [ROW_W:0]     cmd_num_rows = '0;
  logic [K_MAX_W-1:0] cmd_num_vec = '0;
  logic               cmd_reuse_w = 1'b0;
  logic               wgt_valid = 1'b0;
  logic               wgt_ready;
  logic [ROW_W-1:0]   wgt_row_sel;
  logic               wgt_load_en;
  logic               act_valid = 1'b0;
  logic               act_ready;
  logic               act_bubble;
  logic               array_en;
  logic               res_valid;
  logic               res_ready = 1'b0;
  logic               res_last;
  logic               busy;
  logic               done;
  logic               err;
  logic [31:0]        perf_stall_cnt;

  always #5 clk = ~clk;

  neuraedge_ws_sequencer #(
    .PE_ROWS(PE_ROWS), .PE_COLS(PE_COLS), .K_MAX_W(K_MAX_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_num_rows(cmd_num_rows),
    .cmd_num_vec(cmd_num_vec), .cmd_reuse_w(cmd_reuse_w),
    .wgt_valid(wgt_valid), .wgt_ready(wgt_ready), .wgt_row_sel(wgt_row_sel),
    .wgt_load_en(wgt_load_en),
    .act_valid(act_valid), .act_ready(act_ready), .act_bubble(act_bubble),
    .array_en(array_en),
    .res_valid(res_valid), .res_ready(res_ready), .res_last(res_last),
    .busy(busy), .done(done), .err(err), .perf_stall_cnt(perf_stall_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", nm, act, exp);
    end
  endtask

  // Per-command observations taken from DUT outputs.
  int obs_loads, obs_adv, obs_res, obs_last, obs_first, obs_err, obs_perf;
  int m_stall;   // stall cycles predicted by the model
  int mis;       // per-cycle model divergences in the current command

  function automatic void cmp(input string nm, input int a, input int e);
    if (a != e) begin
      if (mis == 0)
        $display("  first divergence at t=%0t on %s: dut %0d model %0d", $time, nm, a, e);
      mis++;
    end
  endfunction

  // Issue one command and follow it until the sequencer is back in IDLE.
  // pv/pr: percent probability of wgt/act valid and of res_ready.
  // hold: res_ready is forced low for this many cycles once results are due.
  task automatic do_cmd(input int rows, input int nvec, input bit reuse,
                        input int pv, input int pr, input int hold);
    int need, lat, total, m_loads, m_adv, hold_left;
    bit illegal, finished, loading, active, inj, outp;
    bit e_ld, e_en, e_ar, e_bub, e_rv, e_last;
    illegal   = (rows < 1) || (rows > PE_ROWS);
    obs_loads = 0; obs_adv = 0; obs_res = 0; obs_last = 0;
    obs_first = -1; obs_err = 0; obs_perf = 0;
    m_stall   = 0; mis = 0;

    @(posedge clk); #1;
    cmd_valid    = 1'b1;
    cmd_num_rows = (ROW_W+1)'(rows);
    cmd_num_vec  = K_MAX_W'(nvec);
    cmd_reuse_w  = reuse;
    @(negedge clk);
    cmp("cmd_ready_on_offer", int'(cmd_ready), 1);

    if (illegal) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      wgt_valid = 1'b1; act_valid = 1'b1; res_ready = 1'b1;
      @(negedge clk);
      obs_err = int'(err);
      cmp("err_cmd_ready", int'(cmd_ready), 0);
      cmp("err_busy",      int'(busy), 0);
      cmp("err_wgt_ready", int'(wgt_ready), 0);
      cmp("err_array_en",  int'(array_en), 0);
      @(posedge clk); #1;
      wgt_valid = 1'b0; act_valid = 1'b0; res_ready = 1'b0;
      @(negedge clk);
      cmp("err_clear",      int'(err), 0);
      cmp("err_ready_back", int'(cmd_ready), 1);
      obs_perf = int'(perf_stall_cnt);
      chk("cycle_model", mis, 0);
      return;
    end

    need      = reuse ? 0 : rows;
    lat       = rows + PE_COLS - 1;
    total     = (nvec == 0) ? 0 : nvec + lat - 1;
    m_loads   = 0;
    m_adv     = 0;
    hold_left = hold;
    finished  = 1'b0;

    for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
      @(posedge clk); #1;
      loading = (m_loads < need);
      active  = !loading && (m_adv < total);
      outp    = (m_adv >= lat - 1);
      // Random command traffic while busy must be ignored.
      cmd_valid    = ($urandom_range(1) == 1);
      cmd_num_rows = (ROW_W+1)'($urandom);
      cmd_num_vec  = K_MAX_W'($urandom);
      cmd_reuse_w  = ($urandom_range(1) == 1);
      wgt_valid    = ($urandom_range(99) < pv);
      act_valid    = ($urandom_range(99) < pv);
      res_ready    = ($urandom_range(99) < pr);
      if (active && outp && hold_left > 0) begin
        res_ready = 1'b0;
        act_valid = 1'b1;
        hold_left--;
      end

      @(negedge clk);
      inj    = (m_adv < nvec);
      e_ld   = loading && wgt_valid;
      e_en   = active && (inj ? act_valid : 1'b1) && (!outp || res_ready);
      e_ar   = active && inj && (!outp || res_ready);
      e_bub  = active && !inj;
      e_rv   = active && outp && (inj ? act_valid : 1'b1);
      e_last = e_rv && (m_adv == total - 1);

      cmp("wgt_ready",   int'(wgt_ready), int'(loading));
      cmp("wgt_row_sel", int'(wgt_row_sel), loading ? m_loads : 0);
      cmp("wgt_load_en", int'(wgt_load_en), int'(e_ld));
      cmp("array_en",    int'(array_en), int'(e_en));
      cmp("act_ready",   int'(act_ready), int'(e_ar));
      cmp("act_bubble",  int'(act_bubble), int'(e_bub));
      cmp("res_valid",   int'(res_valid), int'(e_rv));
      cmp("res_last",    int'(res_last), int'(e_last));
      cmp("done",        int'(done), int'(!loading && !active));
      cmp("busy",        int'(busy), 1);
      cmp("cmd_ready",   int'(cmd_ready), 0);
      cmp("err",         int'(err), 0);

      obs_loads += int'(wgt_load_en);
      if (res_valid && res_ready) obs_res++;
      if (array_en) begin
        if (res_valid && obs_first < 0) obs_first = obs_adv;
        if (res_last) obs_last++;
        obs_adv++;
      end

      if (active && !e_en) m_stall++;
      if (e_ld) m_loads++;
      if (e_en) m_adv++;
      if (!loading && !active) finished = 1'b1;
    end
    chk("cmd_completes", int'(finished), 1);

    @(posedge clk); #1;
    cmd_valid = 1'b0; wgt_valid = 1'b0; act_valid = 1'b0; res_ready = 1'b0;
    @(negedge clk);
    cmp("idle_busy",      int'(busy), 0);
    cmp("idle_cmd_ready", int'(cmd_ready), 1);
    cmp("idle_done",      int'(done), 0);
    obs_perf = int'(perf_stall_cnt);
    chk("cycle_model", mis, 0);
  endtask

  task automatic verify(input string tag, input int e_err, input int e_loads, input int e_adv,
                        input int e_res, input int e_first, input int e_stall);
    int e_perf;
`ifdef NEURAEDGE_SEQ_PERF_EN
    e_perf = e_stall;
`else
    e_perf = 0;
`endif
    chk($sformatf("%s err", tag),         obs_err, e_err);
    chk($sformatf("%s loads", tag),       obs_loads, e_loads);
    chk($sformatf("%s advances", tag),    obs_adv, e_adv);
    chk($sformatf("%s results", tag),     obs_res, e_res);
    chk($sformatf("%s first_res", tag),   obs_first, e_first);
    chk($sformatf("%s res_last", tag),    obs_last, (e_adv > 0) ? 1 : 0);
    chk($sformatf("%s perf_stall", tag),  obs_perf, e_perf);
  endtask

  typedef struct {
    int rows; int nvec; bit reuse; int pv; int pr; int hold;
    int e_err; int e_loads; int e_adv; int e_res; int e_first; int e_stall;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #900000;
    $display("FAIL watchdog simulation did not finish, actual running required finished");
    $fatal(1);
  end

  initial begin
    int r, n, e_loads, e_adv;
    bit reuse, ill;

    tbl[0] = '{4,  3,  1'b0, 100, 100, 0, 0, 4, 69,  3,  66, 0};
    tbl[1] = '{4,  2,  1'b1, 100, 100, 0, 0, 0, 68,  2,  66, 0};
    tbl[2] = '{0,  5,  1'b0, 100, 100, 0, 1, 0, 0,   0,  -1, 0};
    tbl[3] = '{33, 1,  1'b0, 100, 100, 0, 1, 0, 0,   0,  -1, 0};
    tbl[4] = '{4,  3,  1'b0, 100, 100, 5, 0, 4, 69,  3,  66, 5};
    tbl[5] = '{2,  0,  1'b0, 100, 100, 0, 0, 2, 0,   0,  -1, 0};
    tbl[6] = '{32, 2,  1'b1, 100, 100, 0, 0, 0, 96,  2,  94, 0};
    tbl[7] = '{1,  70, 1'b0, 100, 100, 0, 0, 1, 133, 70, 63, 0};
    tbl[8] = '{4,  0,  1'b1, 100, 100, 0, 0, 0, 0,   0,  -1, 0};

    // Values while reset is held.
    #2;
    chk("reset cmd_ready", int'(cmd_ready), 1);
    chk("reset busy",      int'(busy), 0);
    chk("reset wgt_ready", int'(wgt_ready), 0);
    chk("reset array_en",  int'(array_en), 0);
    chk("reset res_valid", int'(res_valid), 0);
    chk("reset done_err",  int'({done, err, act_ready, act_bubble}), 0);
    chk("reset perf",      int'(perf_stall_cnt), 0);
    #20;
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      do_cmd(tbl[i].rows, tbl[i].nvec, tbl[i].reuse, tbl[i].pv, tbl[i].pr, tbl[i].hold);
      verify($sformatf("tbl%0d", i), tbl[i].e_err, tbl[i].e_loads, tbl[i].e_adv,
             tbl[i].e_res, tbl[i].e_first, tbl[i].e_stall);
    end

    // Reset asserted while results are streaming in COMPUTE.
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_num_rows = (ROW_W+1)'(4); cmd_num_vec = K_MAX_W'(100); cmd_reuse_w = 1'b0;
    wgt_valid = 1'b1; act_valid = 1'b1; res_ready = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (80) @(posedge clk);
    @(negedge clk);
    chk("midrst pre busy",      int'(busy), 1);
    chk("midrst pre array_en",  int'(array_en), 1);
    chk("midrst pre res_valid", int'(res_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst busy",      int'(busy), 0);
    chk("midrst array_en",  int'(array_en), 0);
    chk("midrst res_valid", int'(res_valid), 0);
    chk("midrst cmd_ready", int'(cmd_ready), 1);
    wgt_valid = 1'b0; act_valid = 1'b0; res_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_cmd(3, 5, 1'b0, 100, 100, 0);
    verify("post_reset", 0, 3, 5 + 3 + PE_COLS - 2, 5, 3 + PE_COLS - 2, 0);

    // Random commands under random flow control.
    for (int k = 0; k < 20; k++) begin
      if ($urandom_range(99) < 10)
        r = ($urandom_range(1) == 1) ? 0 : int'($urandom_range(33, 63));
      else
        r = int'($urandom_range(1, PE_ROWS));
      n     = ($urandom_range(99) < 15) ? 0 : int'($urandom_range(1, 80));
      reuse = ($urandom_range(1) == 1);
      ill   = (r < 1) || (r > PE_ROWS);
      e_loads = (ill || reuse) ? 0 : r;
      e_adv   = (ill || n == 0) ? 0 : n + r + PE_COLS - 2;
      do_cmd(r, n, reuse, int'($urandom_range(50, 100)), int'($urandom_range(40, 100)), 0);
      verify($sformatf("rnd%0d", k), ill ? 1 : 0, e_loads, e_adv, ill ? 0 : n,
             (e_adv > 0) ? r + PE_COLS - 2 : -1, ill ? 0 : m_stall);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
